// File: rtl/sram_pkg.sv
// ============================================================================
// Module      : sram_pkg
// Description : Shared constants and address-window helper for the
//               instruction SRAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_pkg;

  localparam logic [31:0] BASE_DEFAULT = 32'h1c000000;
  localparam int          WORD_W       = 32;
  localparam int          BE_W         = 4;

  // Addresses below base wrap to a huge offset, so one compare covers both sides.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int          depth_log2);
    logic [31:0] off;
    off = addr - base;
    return (off >> (depth_log2 + 2)) == 32'd0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_word_bank.sv
// ============================================================================
// Module      : sram_word_bank
// Description : Byte-lane write-enabled, read-first single-port word array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_word_bank
  import sram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 16
) (
  input  logic                  clk,
  input  logic                  ce,
  input  logic [BE_W-1:0]       we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];
  logic [WORD_W-1:0] rdata_q;

  // Read-first: the old word is captured on the same edge the lanes update.
  always_ff @(posedge clk) begin
    if (ce) begin
      rdata_q <= mem[idx];
      for (int b = 0; b < BE_W; b++) begin
        if (we[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/inst_sram_resp.sv
// ============================================================================
// Module      : inst_sram_resp
// Description : Instruction-fetch SRAM responder with held read data,
//               out-of-window capture and saturating access counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_sram_resp
  import sram_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 16,
  parameter logic [31:0] BASE       = BASE_DEFAULT,
  parameter int          CNT_W      = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_sram_en,
  input  logic [BE_W-1:0]   inst_sram_we,
  input  logic [31:0]       inst_sram_addr,
  input  logic [WORD_W-1:0] inst_sram_wdata,
  output logic [WORD_W-1:0] inst_sram_rdata,
  output logic              oob_err,
  output logic [31:0]       oob_addr,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt
);

  logic [31:0]           w_off;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_in_win;
  logic                  w_rd;
  logic                  w_wr;
  logic                  w_bank_ce;
  logic [BE_W-1:0]       w_bank_we;
  logic [WORD_W-1:0]     w_bank_rdata;
  logic                  w_unused;

  logic                  zero_q,    zero_d;
  logic                  oob_err_q, oob_err_d;
  logic [31:0]           oob_addr_q, oob_addr_d;
  logic [CNT_W-1:0]      rd_cnt_q,  rd_cnt_d;
  logic [CNT_W-1:0]      wr_cnt_q,  wr_cnt_d;

  assign w_off     = inst_sram_addr - BASE;
  assign w_idx     = w_off[DEPTH_LOG2+1:2];
  assign w_in_win  = in_window(inst_sram_addr, BASE, DEPTH_LOG2);
  assign w_unused  = ^{w_off[31:DEPTH_LOG2+2], w_off[1:0]};

  // Reads are honoured even in reset so the boot fetch lands on the first cycle out.
  assign w_rd      = inst_sram_en && w_in_win && (inst_sram_we == '0);
  assign w_wr      = inst_sram_en && w_in_win && (inst_sram_we != '0) && resetn;
  assign w_bank_ce = w_rd || w_wr;
  assign w_bank_we = w_wr ? inst_sram_we : '0;

  sram_word_bank #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_bank (
    .clk   (clk),
    .ce    (w_bank_ce),
    .we    (w_bank_we),
    .idx   (w_idx),
    .wdata (inst_sram_wdata),
    .rdata (w_bank_rdata)
  );

  // zero_q masks the bank output after reset or an out-of-window access.
  always_comb begin
    zero_d     = zero_q;
    oob_err_d  = oob_err_q;
    oob_addr_d = oob_addr_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    if (w_bank_ce) begin
      zero_d = 1'b0;
    end else if (!resetn || inst_sram_en) begin
      zero_d = 1'b1;
    end
    if (!resetn) begin
      oob_err_d  = 1'b0;
      oob_addr_d = '0;
      rd_cnt_d   = '0;
      wr_cnt_d   = '0;
    end else begin
      if (inst_sram_en && !w_in_win && !oob_err_q) begin
        oob_err_d  = 1'b1;
        oob_addr_d = inst_sram_addr;
      end
      if (w_rd && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + 1'b1;
      if (w_wr && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    zero_q     <= zero_d;
    oob_err_q  <= oob_err_d;
    oob_addr_q <= oob_addr_d;
    rd_cnt_q   <= rd_cnt_d;
    wr_cnt_q   <= wr_cnt_d;
  end

  assign inst_sram_rdata = zero_q ? '0 : w_bank_rdata;
  assign oob_err         = oob_err_q;
  assign oob_addr        = oob_addr_q;
  assign rd_cnt          = rd_cnt_q;
  assign wr_cnt          = wr_cnt_q;

endmodule

`default_nettype wire

// File: doc/inst_sram_resp.md
# inst_sram_resp

Responder end of the `inst_sram_*` fetch interface: a single-port synchronous SRAM model that serves the fetch stage's `en/we/addr/wdata` requests and returns `rdata` one cycle later. It holds its output between requests, because the fetch stage samples `rdata` combinationally while it is stalled. It also supports byte-lane writes for preload/self-modifying tests, flags out-of-window accesses, and keeps read/write access counters for the bench. It sits at the top level beside the CPU core and connects directly to the core's instruction-SRAM port.

## Interface
Parameters:
- `DEPTH_LOG2`, default 16: log2 of the number of 32-bit words (default 256 KiB).
- `BASE`, default 32'h1c000000: byte address of word 0, which matches the first fetch after reset.
- `CNT_W`, default 32: width of each access counter.

Ports:
- `clk`  in  1  clock
- `resetn`  in  1  reset, synchronous, active-low
- `inst_sram_en`  in  1  request strobe
- `inst_sram_we`  in  4  byte write enables; bit i covers `wdata[8i+7:8i]`
- `inst_sram_addr`  in  32  byte address; bits [1:0] are ignored
- `inst_sram_wdata`  in  32  write data
- `inst_sram_rdata`  out  32  registered read data
- `oob_err`  out  1  sticky out-of-window flag
- `oob_addr`  out  32  address of the first out-of-window access
- `rd_cnt`  out  CNT_W  count of accepted reads
- `wr_cnt`  out  CNT_W  count of accepted writes

## Operation
- Offset: `off = addr - BASE` (32-bit, wraps modulo 2^32). Word index `idx = off[DEPTH_LOG2+1:2]`.
- In window: `off[31:DEPTH_LOG2+2] == 0`. Any other address is out of window (OOB), including addresses below `BASE`, since those wrap to a large offset.
- Read: when `en && we==0 && in window`, `rdata <= mem[idx]` at the clock edge, and `rd_cnt` increments.
- Write: when `en && we!=0 && in window && resetn`, each enabled byte lane of `mem[idx]` is updated. `rdata` then loads the old word (read-first), and `wr_cnt` increments. Partial `we` patterns such as 4'b0101 update only the selected lanes.
- OOB with `en=1`:
  - A read loads `rdata <= 0`; a write changes no memory.
  - The counters do not change.
  - If `oob_err` is 0, set `oob_err <= 1` and `oob_addr <= addr`. Later OOB accesses do not overwrite `oob_addr`.
- `en=0`: `rdata` holds its previous value indefinitely. `we`, `addr` and `wdata` are ignored.
- Reset:
  - Clears `rdata`, `oob_err`, `oob_addr`, `rd_cnt` and `wr_cnt` to 0.
  - Memory is not cleared; it is preloaded by the bench via `$readmemh` on the array.
  - Reads are still served in a reset cycle: if `resetn=0 && en=1 && we==0 && in window`, `rdata` loads `mem[idx]` and overrides the clear. This is required because the fetch stage issues `0x1c000000` while in reset and consumes it in the first cycle after reset.
  - Writes are suppressed during reset, and the counters stay at 0 during reset.
- Counters saturate at all-ones; they do not wrap.

## Timing
- Read latency is exactly 1 cycle: a request at edge N gives data valid after edge N, for the whole of cycle N+1 and until the next `en`.
- Back-to-back requests run every cycle with no bubbles. There is no backpressure and no ready signal.
- A write in cycle N followed by a read of the same word in cycle N+1 returns the new data.
- Reset mid-stream: a read request in the reset cycle is served as described above. A write in the reset cycle is dropped.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `sram_pkg`: `BASE_DEFAULT` = 32'h1c000000, `WORD_W` = 32, `BE_W` = 4, and the helper function `in_window(addr, base, depth_log2)`.
- One sub-module: `sram_word_bank`. It holds the byte-lane write-enabled, read-first array, with ports `clk`, `ce`, `we[3:0]`, `idx`, `wdata`, `rdata`.
- The top level contains the window decode, the reset-cycle read override, the hold register, the OOB capture and the counters.

## Test plan
- Preload `mem[0]=32'h02800c0c`, `mem[1]=32'h1c000000`. Hold reset with `en=1`, `addr=0x1c000000`, then release. Required: `rdata=0x02800c0c` in the first post-reset cycle, and `rd_cnt=0`. On the next edge, read `0x1c000004`; required: `rdata=0x1c000000` and `rd_cnt=1`.
- Read `0x1c000008`, then hold `en=0` for 5 cycles while toggling `addr` and `we`. Required: `rdata` is stable at `mem[2]` and the counters are unchanged.
- Start with `mem[3]=0x11223344`. Write `we=4'b0101`, `wdata=0xAABBCCDD` to `0x1c00000c`; required: `rdata=0x11223344` (read-first). Then read the same word; required: `0x11BB33DD` and `wr_cnt=1`.
- Read `0x1bfffffc`, then read `0x1c000000 + 2^(DEPTH_LOG2+2)`. Required: `rdata=0` both times, `oob_err=1`, `oob_addr=0x1bfffffc` (not updated by the second access), and `rd_cnt` unchanged.
- Read `0x1c000013` (misaligned). Required: returns `mem[4]`.
- With `CNT_W=4`, issue 20 reads. Required: `rd_cnt=4'hF`. Then assert reset for 1 cycle; required: `rd_cnt=0`, `oob_err=0`, and a write issued during that cycle leaves memory unchanged.
